fb_scanout: RTL and testbench

Display-side reader of the double-buffered frame buffer. Walks the pixel address in raster order from the video timing counters, issues reads on the RAM's read port, and realigns the returned RGB with delayed sync/active signals for the HDMI/TMDS path. Also owns front/back buffer selection and grants buffer swaps to the pixel writer, only at frame boundaries.

---
 rtl/fb_scanout.sv | 194 +++++++++++++++++++
 tb/tb_fb_scanout.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: raster-order reads from the front buffer, colour/sync realignment, frame-boundary swaps.
// Optional FB_SCANOUT_TEST_PATTERN_EN: blanking shows an hcount/vcount test pattern instead of black.
module fb_scanout #(
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 720,
    parameter int RAM_LATENCY = 2,
    parameter int ADDR_W      = $clog2(2 * WIDTH * HEIGHT)
) (
    input  logic              clk_pixel_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              active_in,
    input  logic              new_frame_in,
    input  logic              swap_req_in,
    output logic              swap_ack_out,
    output logic              front_sel_out,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic              fb_en_out,
    input  logic [23:0]       fb_data_in,
    output logic [7:0]        red_out,
    output logic [7:0]        green_out,
    output logic [7:0]        blue_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              active_out
);

    localparam int FRAME_PIX = WIDTH * HEIGHT;
    localparam int PTR_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int DEPTH     = RAM_LATENCY + 1;

    localparam logic [10:0]       WIDTH_C    = 11'(WIDTH);
    localparam logic [9:0]        HEIGHT_C   = 10'(HEIGHT);
    localparam logic [ADDR_W-1:0] FRAME_BASE = ADDR_W'(FRAME_PIX);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } swapState_e;

    swapState_e        state_q, state_d;
    logic              frontSel_q, frontSel_d;
    logic              swapNow;
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptrInc;
    logic [ADDR_W-1:0] addr_q, addr_d, baseNew;
    logic              en_q, en_d;
    logic              inFrame;

    // Timing delay line, one entry per cycle from sample to RAM data: {inFrame, hsync, vsync, active}
    logic [3:0]        tmgPipe_q [DEPTH];
    logic [3:0]        tmgLast;
    logic [23:0]       fill;
    logic [23:0]       pixel_d, pixel_q;
    logic [2:0]        sync_q;

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    logic [7:0]        hcPipe_q [DEPTH];
    logic [7:0]        vcPipe_q [DEPTH];
`endif

    // Swap handshake: the toggle is only ever granted on a new_frame_in cycle, once per request
    always_comb begin
        state_d = state_q;
        swapNow = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (swap_req_in) begin
                    if (new_frame_in) begin
                        state_d = S_ACK;
                        swapNow = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (new_frame_in) begin
                    state_d = S_ACK;
                    swapNow = 1'b1;
                end else if (!swap_req_in) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  if (!swap_req_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        frontSel_d = frontSel_q ^ swapNow;
    end

    assign inFrame = active_in && (hcount_in < WIDTH_C) && (vcount_in < HEIGHT_C);
    assign baseNew = frontSel_d ? FRAME_BASE : '0;
    assign ptrInc  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

    // baseNew already reflects a swap granted this cycle, so the first pixel of the frame reads the new buffer
    always_comb begin
        ptr_d  = ptr_q;
        addr_d = addr_q;
        en_d   = 1'b0;
        if (new_frame_in) begin
            addr_d = baseNew;
            en_d   = inFrame;
            ptr_d  = inFrame ? PTR_W'(1) : '0;
        end else if (inFrame) begin
            addr_d = baseNew + ADDR_W'(ptr_q);
            en_d   = 1'b1;
            ptr_d  = ptrInc;
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            frontSel_q <= 1'b0;
            ptr_q      <= '0;
            addr_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            frontSel_q <= frontSel_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                tmgPipe_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                tmgPipe_q[i] <= tmgPipe_q[i-1];
            end
            tmgPipe_q[0] <= {inFrame, hsync_in, vsync_in, active_in};
        end
    end

    assign tmgLast = tmgPipe_q[DEPTH-1];

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                hcPipe_q[i] <= '0;
                vcPipe_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                hcPipe_q[i] <= hcPipe_q[i-1];
                vcPipe_q[i] <= vcPipe_q[i-1];
            end
            hcPipe_q[0] <= hcount_in[7:0];
            vcPipe_q[0] <= vcount_in[7:0];
        end
    end

    assign fill = {hcPipe_q[DEPTH-1], vcPipe_q[DEPTH-1],
                   hcPipe_q[DEPTH-1] + vcPipe_q[DEPTH-1]};
`else
    assign fill = 24'h0;
`endif

    assign pixel_d = tmgLast[3] ? fb_data_in : fill;

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            pixel_q <= '0;
            sync_q  <= '0;
        end else begin
            pixel_q <= pixel_d;
            sync_q  <= tmgLast[2:0];
        end
    end

    assign swap_ack_out  = (state_q == S_ACK);
    assign front_sel_out = frontSel_q;
    assign fb_addr_out   = addr_q;
    assign fb_en_out     = en_q;
    assign red_out       = pixel_q[23:16];
    assign green_out     = pixel_q[15:8];
    assign blue_out      = pixel_q[7:0];
    assign hsync_out     = sync_q[2];
    assign vsync_out     = sync_q[1];
    assign active_out    = sync_q[0];

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a 4x2 frame with a latency-2 RAM model whose content equals its address.
module tb_fb_scanout;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int LAT  = 2;
    localparam int AW   = 4;
    localparam int HTOT = 7;
    localparam int VTOT = 4;

    logic          clk_pixel_in = 1'b0;
    logic          rst_in = 1'b0;
    logic [10:0]   hcount_in = '0;
    logic [9:0]    vcount_in = '0;
    logic          hsync_in = 1'b0, vsync_in = 1'b0, active_in = 1'b0;
    logic          new_frame_in = 1'b0;
    logic          swap_req_in = 1'b0;
    logic          swap_ack_out, front_sel_out;
    logic [AW-1:0] fb_addr_out;
    logic          fb_en_out;
    logic [23:0]   fb_data_in;
    logic [7:0]    red_out, green_out, blue_out;
    logic          hsync_out, vsync_out, active_out;

    fb_scanout #(.WIDTH(W), .HEIGHT(H), .RAM_LATENCY(LAT)) dut (
        .clk_pixel_in (clk_pixel_in),
        .rst_in       (rst_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .active_in    (active_in),
        .new_frame_in (new_frame_in),
        .swap_req_in  (swap_req_in),
        .swap_ack_out (swap_ack_out),
        .front_sel_out(front_sel_out),
        .fb_addr_out  (fb_addr_out),
        .fb_en_out    (fb_en_out),
        .fb_data_in   (fb_data_in),
        .red_out      (red_out),
        .green_out    (green_out),
        .blue_out     (blue_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .active_out   (active_out)
    );

    always #5 clk_pixel_in = ~clk_pixel_in;

    // RAM read port: address registered, then one output register, content = address in every channel
    logic [23:0] ramS1 = '0;
    logic [23:0] ramS2 = '0;
    always @(posedge clk_pixel_in) begin
        if (fb_en_out) ramS1 <= {3{{4'b0, fb_addr_out}}};
        ramS2 <= ramS1;
    end
    assign fb_data_in = ramS2;

    typedef struct {
        int due;
        bit en;
        int addr;
        bit ack;
        bit front;
    } immExp_t;

    typedef struct {
        int due;
        int r, g, b;
        bit hs, vs, act;
    } outExp_t;

    immExp_t immQ[$];
    outExp_t outQ[$];
    int      cyc = 0;
    int      errors = 0;
    int      checks = 0;

    always @(posedge clk_pixel_in) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one timing cycle and queue what the DUT must show 1 and 4 cycles later
    task automatic applyStimulus(input int h, input int v, input bit front, input bit ackNext);
        immExp_t ie;
        outExp_t oe;
        bit act, inFrame;
        int fillR, fillG, fillB, pixAddr;
        act     = (h < 5) && (v < H);
        inFrame = act && (h < W) && (v < H);
        pixAddr = (front ? W * H : 0) + v * W + h;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
        fillR = h & 255;
        fillG = v & 255;
        fillB = (h + v) & 255;
`else
        fillR = 0;
        fillG = 0;
        fillB = 0;
`endif
        ie.due   = cyc + 1;
        ie.en    = inFrame;
        ie.addr  = pixAddr;
        ie.ack   = ackNext;
        ie.front = front;
        immQ.push_back(ie);
        oe.due = cyc + 2 + LAT;
        oe.r   = inFrame ? pixAddr : fillR;
        oe.g   = inFrame ? pixAddr : fillG;
        oe.b   = inFrame ? pixAddr : fillB;
        oe.hs  = (h == 5);
        oe.vs  = (v == 3);
        oe.act = act;
        outQ.push_back(oe);
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        active_in    = act;
        hsync_in     = (h == 5);
        vsync_in     = (v == 3);
        new_frame_in = (h == 0) && (v == 0);
        @(posedge clk_pixel_in);
        #1;
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_rgb"}, int'({red_out, green_out, blue_out}), 0);
        checkOutput({name, "_ctrl"}, int'({fb_en_out, fb_addr_out, swap_ack_out, front_sel_out,
                                          hsync_out, vsync_out, active_out}), 0);
    endtask

    task automatic midFrameReset();
        #1 rst_in = 1'b0;
        #1 checkResetOutputs("midreset");
        immQ.delete();
        outQ.delete();
        swap_req_in = 1'b0;
        repeat (2) @(posedge clk_pixel_in);
        #1 rst_in = 1'b1;
    endtask

    // One full frame; reqOn/reqOff/resetAt are cycle indices within the frame, -1 for none
    task automatic runFrame(input bit front, input bit ack, input int reqOn, input int reqOff,
                            input int resetAt);
        for (int v = 0; v < VTOT; v++) begin
            for (int h = 0; h < HTOT; h++) begin
                int idx;
                idx = v * HTOT + h;
                if (idx == resetAt) begin
                    midFrameReset();
                    return;
                end
                if (idx == reqOn)  swap_req_in = 1'b1;
                if (idx == reqOff) swap_req_in = 1'b0;
                applyStimulus(h, v, front, ack && (idx == 0));
            end
        end
    endtask

    // Monitor: pops every expectation due this cycle and compares against the DUT
    immExp_t mi;
    outExp_t mo;
    always @(negedge clk_pixel_in) begin
        if (rst_in) begin
            while (immQ.size() > 0 && immQ[0].due <= cyc) begin
                mi = immQ.pop_front();
                checkOutput("fb_en", int'(fb_en_out), int'(mi.en));
                if (mi.en) checkOutput("fb_addr", int'(fb_addr_out), mi.addr);
                checkOutput("swap_ack", int'(swap_ack_out), int'(mi.ack));
                checkOutput("front_sel", int'(front_sel_out), int'(mi.front));
            end
            while (outQ.size() > 0 && outQ[0].due <= cyc) begin
                mo = outQ.pop_front();
                checkOutput("red", int'(red_out), mo.r);
                checkOutput("green", int'(green_out), mo.g);
                checkOutput("blue", int'(blue_out), mo.b);
                checkOutput("hsync", int'(hsync_out), int'(mo.hs));
                checkOutput("vsync", int'(vsync_out), int'(mo.vs));
                checkOutput("active", int'(active_out), int'(mo.act));
            end
        end
    end

    initial begin
        $display("[TB] start fb_scanout %0dx%0d latency %0d", W, H, LAT);
        repeat (2) @(posedge clk_pixel_in);
        #1 checkResetOutputs("reset");
        rst_in = 1'b1;

        runFrame(1'b0, 1'b0, -1, -1, -1);
        runFrame(1'b1, 1'b1,  0, -1, -1);
        runFrame(1'b1, 1'b0, -1, -1, -1);
        runFrame(1'b1, 1'b0, -1,  3, -1);
        runFrame(1'b1, 1'b0, 10, -1, -1);
        runFrame(1'b0, 1'b1, -1,  5, -1);
        runFrame(1'b0, 1'b0,  5,  9, -1);
        runFrame(1'b0, 1'b0, -1, -1, -1);
        runFrame(1'b1, 1'b1,  0,  3, -1);
        runFrame(1'b1, 1'b0, -1, -1,  9);
        runFrame(1'b0, 1'b0, -1, -1, -1);
        runFrame(1'b1, 1'b1,  0,  3, -1);

        repeat (8) @(posedge clk_pixel_in);
        #1 checkOutput("queues_drained", immQ.size() + outQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
